hazard_scoreboard: RTL and testbench

//  Parametrised successor to the combinational decode controller. It consumes the

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/mdu_busy_counter.sv | 36 +++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard: slot entry layout,
// the "operand unused" Tuse marker, MDU latencies and forward-select encodings.
package hazard_pkg;

  localparam int SB_RAW       = 5;
  localparam int SB_TW        = 4;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  localparam logic [SB_TW-1:0] TUSE_NONE = SB_TW'(7);

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  typedef struct packed {
    logic              valid;
    logic [SB_RAW-1:0] a3;
    logic [SB_TW-1:0]  tnew;
  } sb_entry_t;

endpackage

// File: rtl/mdu_busy_counter.sv
// Multiply/divide occupancy counter: loads the op latency on issue, counts down to idle.
module mdu_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic isdiv,
  output logic busy
);

  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = isdiv ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard controller: in-flight GRF writer scoreboard (E..W) driving stall,
// bubble and forward selects, plus multiply/divide unit interlock.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int RAW      = SB_RAW,
  parameter int TW       = SB_TW,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RAW-1:0] D_rs_addr,
  input  logic [RAW-1:0] D_rt_addr,
  input  logic [TW-1:0]  D_rs_Tuse,
  input  logic [TW-1:0]  D_rt_Tuse,
  input  logic [TW-1:0]  D_Tnew,
  input  logic [RAW-1:0] D_A3,
  input  logic          D_GRF_write,
  input  logic          D_MDU_start,
  input  logic          D_MDU_isdiv,
  input  logic          D_MDU_use,
  output logic          stall,
  output logic          E_bubble,
  output logic [1:0]    D_rs_fwd_sel,
  output logic [1:0]    D_rt_fwd_sel,
  output logic          mdu_busy
);

  sb_entry_t slot_q [NSTAGE];
  sb_entry_t slot_d [NSTAGE];
  logic      rs_stall, rt_stall, mdu_stall;

  // Only the newest (lowest index) match counts; older writers of the same
  // register are shadowed for both stall and forwarding.
  function automatic logic [2:0] lookup(input sb_entry_t s [NSTAGE],
                                        input logic [RAW-1:0] r,
                                        input logic [TW-1:0] tuse);
    logic       found;
    logic       stl;
    logic [1:0] sel;
    found = 1'b0;
    stl   = 1'b0;
    sel   = FWD_GRF;
    for (int i = 0; i < NSTAGE; i++) begin
      if (!found && s[i].valid && s[i].a3 == r && r != '0) begin
        found = 1'b1;
        stl   = (tuse != TUSE_NONE) && (s[i].tnew > tuse);
        if (s[i].tnew == '0) sel = 2'(i + 1);
      end
    end
    return {stl, sel};
  endfunction

  always_comb begin
    {rs_stall, D_rs_fwd_sel} = lookup(slot_q, D_rs_addr, D_rs_Tuse);
    {rt_stall, D_rt_fwd_sel} = lookup(slot_q, D_rt_addr, D_rt_Tuse);
    mdu_stall = D_MDU_use && mdu_busy;
    stall     = rs_stall || rt_stall || mdu_stall;
    E_bubble  = stall;
  end

  always_comb begin
    slot_d[0] = '0;
    if (!stall) begin
      slot_d[0].valid = D_GRF_write && (D_A3 != '0);
      slot_d[0].a3    = D_A3;
      slot_d[0].tnew  = D_Tnew;
    end
    for (int i = 1; i < NSTAGE; i++) begin
      slot_d[i] = slot_q[i-1];
      if (slot_q[i-1].tnew != '0) slot_d[i].tnew = slot_q[i-1].tnew - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) slot_q[i] <= slot_d[i];
    end
  end

  mdu_busy_counter #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_mdu (
    .clk  (clk),
    .reset(reset),
    .load (D_MDU_start && !stall),
    .isdiv(D_MDU_isdiv),
    .busy (mdu_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: hand-derived per-cycle expectations queued
// as each D instruction is driven, compared against the outputs at the falling edge.
module tb_hazard_scoreboard;

  typedef struct {
    logic [4:0] rs;
    logic [3:0] rs_t;
    logic [4:0] rt;
    logic [3:0] rt_t;
    logic [4:0] a3;
    logic [3:0] tnew;
    logic       wr;
    logic       st;
    logic       dv;
    logic       us;
  } instr_t;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs_addr, D_rt_addr, D_A3;
  logic [3:0] D_rs_Tuse, D_rt_Tuse, D_Tnew;
  logic       D_GRF_write, D_MDU_start, D_MDU_isdiv, D_MDU_use;
  logic       stall, E_bubble, mdu_busy;
  logic [1:0] D_rs_fwd_sel, D_rt_fwd_sel;

  int n_total = 0;
  int n_pass  = 0;
  logic [6:0] exp_q [$];
  logic [6:0] got, e;

  // {stall, E_bubble, rs_sel, rt_sel, mdu_busy}
  wire [6:0] outv = {stall, E_bubble, D_rs_fwd_sel, D_rt_fwd_sel, mdu_busy};

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs_addr   (D_rs_addr),
    .D_rt_addr   (D_rt_addr),
    .D_rs_Tuse   (D_rs_Tuse),
    .D_rt_Tuse   (D_rt_Tuse),
    .D_Tnew      (D_Tnew),
    .D_A3        (D_A3),
    .D_GRF_write (D_GRF_write),
    .D_MDU_start (D_MDU_start),
    .D_MDU_isdiv (D_MDU_isdiv),
    .D_MDU_use   (D_MDU_use),
    .stall       (stall),
    .E_bubble    (E_bubble),
    .D_rs_fwd_sel(D_rs_fwd_sel),
    .D_rt_fwd_sel(D_rt_fwd_sel),
    .mdu_busy    (mdu_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic instr_t mk(logic [4:0] rs, logic [3:0] rs_t, logic [4:0] rt,
                                logic [3:0] rt_t, logic [4:0] a3, logic [3:0] tnew,
                                logic wr, logic st, logic dv, logic us);
    instr_t x;
    x.rs = rs; x.rs_t = rs_t; x.rt = rt; x.rt_t = rt_t; x.a3 = a3;
    x.tnew = tnew; x.wr = wr; x.st = st; x.dv = dv; x.us = us;
    return x;
  endfunction

  function automatic instr_t nop();
    return mk(0, 7, 0, 7, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input instr_t x);
    D_rs_addr = x.rs;  D_rs_Tuse = x.rs_t;
    D_rt_addr = x.rt;  D_rt_Tuse = x.rt_t;
    D_A3 = x.a3;  D_Tnew = x.tnew;  D_GRF_write = x.wr;
    D_MDU_start = x.st;  D_MDU_isdiv = x.dv;  D_MDU_use = x.us;
  endtask

  task automatic do_reset();
    drive(nop());
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(mk(1, 0, 2, 0, 3, 1, 1, 1, 1, 1));
    exp_q.push_back(7'b0_0_00_00_0);
    #2;
    got = outv; e = exp_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL reset_t0: got %b want %b", got, e);
    else n_pass++;
    @(posedge clk);
    exp_q.push_back(7'b0_0_00_00_0);
    @(negedge clk);
    got = outv; e = exp_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL reset_held: got %b want %b", got, e);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(2, 1, 0, 7, 1, 3, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // lw $1
    p.push_back(mk(1, 1, 1, 1, 2, 1, 1, 0, 0, 0)); x.push_back(7'b1_1_00_00_0); // add $2,$1,$1
    p.push_back(mk(1, 1, 1, 1, 2, 1, 1, 0, 0, 0)); x.push_back(7'b1_1_00_00_0);
    p.push_back(mk(1, 1, 1, 1, 2, 1, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0);
    p.push_back(nop());                            x.push_back(7'b0_0_00_00_0);
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL load_use cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(0, 1, 0, 7, 1, 2, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // ori $1
    p.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(7'b1_1_00_00_0); // beq $1,$0
    p.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(7'b1_1_00_00_0);
    p.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(7'b0_0_11_00_0);
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL branch cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_forward();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(0, 7, 0, 7, 1, 1, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // add $1
    p.push_back(nop());                            x.push_back(7'b0_0_00_00_0);
    p.push_back(mk(1, 1, 0, 7, 0, 0, 0, 0, 0, 0)); x.push_back(7'b0_0_10_00_0); // $1 from M
    p.push_back(mk(0, 7, 0, 7, 4, 0, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // writer $4, Tnew0
    p.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0)); x.push_back(7'b0_0_00_01_0); // $1 gone, $4 from E
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL forward cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_zero_reg();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(1, 1, 2, 1, 0, 1, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // add $0,$1,$2
    p.push_back(mk(0, 0, 0, 0, 5, 1, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // uses $0
    p.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(7'b0_0_00_00_0);
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL zero_reg cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_shadow();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(0, 1, 0, 1, 3, 1, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // add $3
    p.push_back(mk(0, 1, 0, 7, 3, 2, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // ori $3
    p.push_back(mk(0, 1, 3, 2, 0, 0, 0, 0, 0, 0)); x.push_back(7'b0_0_00_00_0); // sw rt=$3
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL shadow cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_mflo();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(1, 1, 2, 1, 0, 0, 0, 1, 1, 1)); x.push_back(7'b0_0_00_00_0); // div
    for (int c = 0; c < 10; c++) begin
      p.push_back(mk(0, 7, 0, 7, 5, 1, 1, 0, 0, 1)); x.push_back(7'b1_1_00_00_1); // mflo
    end
    p.push_back(mk(0, 7, 0, 7, 5, 1, 1, 0, 0, 1)); x.push_back(7'b0_0_00_00_0);
    p.push_back(nop());                            x.push_back(7'b0_0_00_00_0);
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL div_mflo cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(1, 1, 2, 1, 0, 0, 0, 1, 0, 1)); x.push_back(7'b0_0_00_00_0); // mult
    for (int c = 0; c < 5; c++) begin
      p.push_back(mk(1, 1, 2, 1, 0, 0, 0, 1, 0, 1)); x.push_back(7'b1_1_00_00_1);
    end
    p.push_back(mk(1, 1, 2, 1, 0, 0, 0, 1, 0, 1)); x.push_back(7'b0_0_00_00_0);
    p.push_back(nop());                            x.push_back(7'b0_0_00_00_1);
    p.push_back(nop());                            x.push_back(7'b0_0_00_00_1);
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL back_to_back cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    instr_t p [$];
    logic [6:0] x [$];
    do_reset();
    p.push_back(mk(1, 1, 2, 1, 0, 0, 0, 1, 0, 1)); x.push_back(7'b0_0_00_00_0); // mult
    p.push_back(mk(0, 1, 0, 1, 6, 1, 1, 0, 0, 0)); x.push_back(7'b0_0_00_00_1); // add $6
    p.push_back(nop());                            x.push_back(7'b0_0_00_00_1);
    p.push_back(mk(6, 0, 0, 7, 7, 1, 1, 0, 0, 1)); x.push_back(7'b1_1_10_00_1); // mfhi-style reader
    foreach (p[k]) begin
      drive(p[k]);
      exp_q.push_back(x[k]);
      @(negedge clk);
      got = outv; e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL async_reset cyc%0d: got %b want %b", k, got, e);
      else n_pass++;
      if (k < p.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    reset = 1'b1;
    exp_q.push_back(7'b0_0_00_00_0);
    #1;
    got = outv; e = exp_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL async_reset_midcycle: got %b want %b", got, e);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(mk(0, 7, 0, 7, 7, 1, 1, 0, 0, 1));
    exp_q.push_back(7'b0_0_00_00_0);
    @(negedge clk);
    got = outv; e = exp_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL async_reset_after: got %b want %b", got, e);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_forward();
    test_zero_reg();
    test_shadow();
    test_div_mflo();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
